pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline register stage with a valid/ready handshake, a two-entry skid buffer, flush, and hazard-unit stall. It replaces the per-stage hand-written registers between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Every stage instantiates it with its own payload widths. Control fields are forced to zero whenever the output holds a bubble, so downstream enables (register-file, SFR, memory writes) can never fire on stale data.

## Interface
Parameters:
- DATA_W, default 32: width of the datapath payload (operands, instruction word).
- CTRL_W, default 16: width of the control payload (write enables, mux selects, memory enables).
- SKID, default 1: 1 gives a two-entry skid buffer with registered in_ready; 0 gives a single register with combinational in_ready.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- nreset  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream stage presents a valid entry.
- in_ready  out  1  stage can accept an entry this cycle.
- in_data  in  DATA_W  upstream datapath payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  output holds a valid entry.
- out_ready  in  1  downstream stage accepts the entry.
- out_data  out  DATA_W  datapath payload of the head entry.
- out_ctrl  out  CTRL_W  control payload of the head entry; all zeros when out_valid=0.
- stall  in  1  hazard-unit hold; while high, the stage behaves as if out_ready=0.
- flush  in  1  synchronous kill of all held entries (branch or exception squash).
- occupancy  out  2  number of valid entries held (0..2; 0..1 when SKID=0).

## Operation
- Accept: in_valid && in_ready at a rising edge.
- Issue: out_valid && out_ready && !stall at a rising edge.
- Storage: a main register (head) plus, when SKID=1, a skid register. Order is strict FIFO and no entry is ever duplicated or dropped except by flush.
- SKID=1 transitions:
  - Empty + accept: the entry goes to main.
  - Main full, issue + accept: the new entry goes to main.
  - Main full, no issue, accept: the new entry goes to skid.
  - Both full + issue: skid moves to main, and skid becomes empty.
- SKID=1 ready: in_ready = !skid_valid && !flush, taken from registered state only. in_ready never depends on out_ready or stall in the same cycle.
- SKID=0 ready: in_ready = (!main_valid || (out_ready && !stall)) && !flush. Simultaneous issue and accept replaces the head entry.
- Flush: both valid bits clear at the next edge. Any accept in the flush cycle is discarded, and in_ready is forced to 0. Flush takes priority over stall and over issue. out_valid in the flush cycle still reflects current state, but the entry is not counted as issued to the downstream stage, which must also be flushed by the hazard unit.
- Bubble masking: out_ctrl = out_valid ? ctrl_main : 0. out_data is not masked and keeps its last value.
- Stall: freezes all entries. Accepts are still permitted while a free slot exists (SKID=1).
- occupancy = main_valid + skid_valid.

## Timing
- Latency: an entry accepted at edge N appears on out_* after edge N (one cycle) when the stage was empty.
- Throughput: one entry per cycle sustained when out_ready=1 and stall=0.
- Reset (nreset=0 at an edge):
  - Valid bits, data registers and ctrl registers are cleared to 0.
  - While nreset=0: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=0.
  - in_ready=1 in the first cycle after nreset is released.
  - Reset mid-operation discards all entries. Reset overrides flush, stall and both handshakes.
- Out-of-bounds conditions:
  - Full (occupancy=2) with in_valid: no accept, and no entry is lost.
  - Empty with out_ready: no issue, and out_ctrl stays 0.
- Coincident events: flush + stall resolves as flush. Flush + accept means the accept is dropped.

## Test plan
- Reset: hold nreset=0 for 3 cycles with in_valid=1 → out_valid=0, out_ctrl=0, occupancy=0, in_ready=0; after release, in_ready=1.
- Streaming: SKID=1, push data 0x11..0x18 back to back with out_ready=1, stall=0 → outputs 0x11..0x18 in order, one per cycle, first one a cycle after its accept.
- Backpressure: push 0x0A and 0x0B with out_ready=0 → occupancy=2 and in_ready=0, 0x0C is held off. Raise out_ready → 0x0A, 0x0B, 0x0C in order, with no loss.
- Stall masking: entry with ctrl 0xFFFF, assert stall for 4 cycles → out_ctrl=0xFFFF held and not issued. After the entry issues and the stage empties → out_ctrl=0x0000.
- Flush: occupancy=2 with in_valid=1 and stall=1, assert flush one cycle → next cycle occupancy=0, out_valid=0, and the concurrent input is not captured.
- SKID=0 instance: full with out_ready=1 and in_valid=1 every cycle → in_ready=1 combinationally, replacement every cycle, occupancy stays 1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one register stage between two pipeline stages.
// It uses a valid/ready handshake and has an optional second (skid) entry,
// so that in_ready can come from a register. It also supports a flush and a
// hazard-unit stall. Control payload is zeroed whenever the head entry is a
// bubble, so downstream enables never fire on stale data.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              accept;
    logic              issue;

    // Ready: in skid mode this depends only on held state; otherwise it allows a same-cycle replacement.
    always_comb begin
        if (SKID != 0)
            in_ready = nreset && !flush && !skid_valid;
        else
            in_ready = nreset && !flush && (!main_valid || (out_ready && !stall));
    end

    // Output view of the head entry; all zeros while reset is held, ctrl masked on bubbles.
    always_comb begin
        out_valid = nreset && main_valid;
        out_data  = nreset ? main_data : '0;
        out_ctrl  = out_valid ? main_ctrl : '0;
        occupancy = nreset ? ({1'b0, main_valid} + {1'b0, skid_valid}) : 2'd0;
    end

    // Handshake events; a flushed head is never counted as issued.
    always_comb begin
        accept = in_valid && in_ready;
        issue  = out_valid && out_ready && !stall && !flush;
    end

    // Entry storage: strict FIFO of head plus skid; reset beats flush, and flush beats everything else.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (issue) begin
            if (skid_valid) begin
                // Skid is full, so nothing was accepted; promote the older entry.
                main_data  <= skid_data;
                main_ctrl  <= skid_ctrl;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
                main_ctrl  <= in_ctrl;
            end else if (SKID != 0) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
                skid_ctrl  <= in_ctrl;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid instance plus a single-register instance.
module tb_pipe_stage_reg;

    logic        clock = 1'b0;
    logic        nreset;
    int          checks = 0;
    int          failures = 0;

    // Skid instance signals
    logic        in_valid, in_ready, out_valid, out_ready, stall, flush;
    logic [31:0] in_data, out_data;
    logic [15:0] in_ctrl, out_ctrl;
    logic [1:0]  occupancy;

    // Single-register instance signals
    logic        s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready, s0_stall, s0_flush;
    logic [31:0] s0_in_data, s0_out_data;
    logic [15:0] s0_in_ctrl, s0_out_ctrl;
    logic [1:0]  s0_occupancy;

    always #5 clock = ~clock;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(1)) dut (
        .clock(clock), .nreset(nreset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall(stall), .flush(flush), .occupancy(occupancy)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(0)) dut_s0 (
        .clock(clock), .nreset(nreset),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data), .in_ctrl(s0_in_ctrl),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data), .out_ctrl(s0_out_ctrl),
        .stall(s0_stall), .flush(s0_flush), .occupancy(s0_occupancy)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        in_valid = 1'b1; in_data = 32'h55; in_ctrl = 16'h1234;
        out_ready = 1'b1; stall = 1'b0; flush = 1'b0;
        s0_in_valid = 1'b1; s0_in_data = 32'h66; s0_in_ctrl = 16'h4321;
        s0_out_ready = 1'b1; s0_stall = 1'b0; s0_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
            checks++; if (out_ctrl !== 16'h0) begin failures++; $display("FAIL reset_out_ctrl got=%h exp=0000", out_ctrl); end
            checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
            checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
            checks++; if (s0_in_ready !== 1'b0) begin failures++; $display("FAIL reset_s0_in_ready got=%b exp=0", s0_in_ready); end
        end
        in_valid = 1'b0; s0_in_valid = 1'b0;
        nreset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        checks++; if (s0_in_ready !== 1'b1) begin failures++; $display("FAIL release_s0_in_ready got=%b exp=1", s0_in_ready); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1; stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 32'h11 + i; in_ctrl = 16'h0100 + i[15:0];
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
            checks++; if (out_data !== 32'h11 + i) begin failures++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data, 32'h11 + i); end
            checks++; if (out_ctrl !== 16'h0100 + i[15:0]) begin failures++; $display("FAIL stream_ctrl[%0d] got=%h exp=%h", i, out_ctrl, 16'h0100 + i[15:0]); end
            checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, occupancy); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain_valid got=%b exp=0", out_valid); end
        checks++; if (out_ctrl !== 16'h0) begin failures++; $display("FAIL stream_drain_ctrl got=%h exp=0000", out_ctrl); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; stall = 1'b0;
        in_valid = 1'b1; in_data = 32'h0A; in_ctrl = 16'h000A;
        step();
        in_data = 32'h0B; in_ctrl = 16'h000B;
        step();
        checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL bp_occ_full got=%0d exp=2", occupancy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full got=%b exp=0", in_ready); end
        checks++; if (out_data !== 32'h0A) begin failures++; $display("FAIL bp_head got=%h exp=0a", out_data); end
        in_data = 32'h0C; in_ctrl = 16'h000C;
        step();
        checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL bp_occ_held got=%0d exp=2", occupancy); end
        checks++; if (out_data !== 32'h0A) begin failures++; $display("FAIL bp_head_held got=%h exp=0a", out_data); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_registered got=%b exp=0", in_ready); end
        step();
        checks++; if (out_data !== 32'h0B) begin failures++; $display("FAIL bp_drain1 got=%h exp=0b", out_data); end
        checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL bp_drain1_occ got=%0d exp=1", occupancy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_drain1_ready got=%b exp=1", in_ready); end
        step();
        checks++; if (out_data !== 32'h0C) begin failures++; $display("FAIL bp_drain2 got=%h exp=0c", out_data); end
        checks++; if (out_ctrl !== 16'h000C) begin failures++; $display("FAIL bp_drain2_ctrl got=%h exp=000c", out_ctrl); end
        checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL bp_drain2_occ got=%0d exp=1", occupancy); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty_valid got=%b exp=0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL bp_empty_occ got=%0d exp=0", occupancy); end
    endtask

    task automatic test_stall_masking();
        out_ready = 1'b1; stall = 1'b0;
        in_valid = 1'b1; in_data = 32'h77; in_ctrl = 16'hFFFF;
        step();
        in_valid = 1'b0; stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, out_valid); end
            checks++; if (out_ctrl !== 16'hFFFF) begin failures++; $display("FAIL stall_ctrl[%0d] got=%h exp=ffff", i, out_ctrl); end
            checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL stall_occ[%0d] got=%0d exp=1", i, occupancy); end
        end
        stall = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL unstall_valid got=%b exp=0", out_valid); end
        checks++; if (out_ctrl !== 16'h0000) begin failures++; $display("FAIL unstall_ctrl got=%h exp=0000", out_ctrl); end
        checks++; if (out_data !== 32'h77) begin failures++; $display("FAIL unstall_data_kept got=%h exp=77", out_data); end
        step();
        checks++; if (out_ctrl !== 16'h0000) begin failures++; $display("FAIL empty_ready_ctrl got=%h exp=0000", out_ctrl); end
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL empty_ready_occ got=%0d exp=0", occupancy); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; stall = 1'b0;
        in_valid = 1'b1; in_data = 32'h21; in_ctrl = 16'h0021;
        step();
        in_data = 32'h22; in_ctrl = 16'h0022;
        step();
        checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=2", occupancy); end
        in_data = 32'h23; in_ctrl = 16'h0023; stall = 1'b1; flush = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_cycle_valid got=%b exp=1", out_valid); end
        step();
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        checks++; if (out_ctrl !== 16'h0) begin failures++; $display("FAIL flush_ctrl got=%h exp=0000", out_ctrl); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_capture got=%b exp=0", out_valid); end
        // Accept a fresh entry, then reset in the middle of operation.
        in_valid = 1'b1; in_data = 32'h44; in_ctrl = 16'h0044; out_ready = 1'b0;
        step();
        checks++; if (out_data !== 32'h44) begin failures++; $display("FAIL post_flush_accept got=%h exp=44", out_data); end
        nreset = 1'b0;
        step();
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL midreset_occ got=%0d exp=0", occupancy); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL midreset_data got=%h exp=0", out_data); end
        in_valid = 1'b0; nreset = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_after_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_skid0();
        s0_out_ready = 1'b1; s0_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s0_in_valid = 1'b1; s0_in_data = 32'h31 + i; s0_in_ctrl = 16'h0200 + i[15:0];
            #1;
            checks++; if (s0_in_ready !== 1'b1) begin failures++; $display("FAIL s0_in_ready[%0d] got=%b exp=1", i, s0_in_ready); end
            step();
            checks++; if (s0_out_data !== 32'h31 + i) begin failures++; $display("FAIL s0_data[%0d] got=%h exp=%h", i, s0_out_data, 32'h31 + i); end
            checks++; if (s0_out_ctrl !== 16'h0200 + i[15:0]) begin failures++; $display("FAIL s0_ctrl[%0d] got=%h exp=%h", i, s0_out_ctrl, 16'h0200 + i[15:0]); end
            checks++; if (s0_occupancy !== 2'd1) begin failures++; $display("FAIL s0_occ[%0d] got=%0d exp=1", i, s0_occupancy); end
        end
        s0_out_ready = 1'b0;
        #1;
        checks++; if (s0_in_ready !== 1'b0) begin failures++; $display("FAIL s0_ready_blocked got=%b exp=0", s0_in_ready); end
        s0_out_ready = 1'b1; s0_stall = 1'b1;
        #1;
        checks++; if (s0_in_ready !== 1'b0) begin failures++; $display("FAIL s0_ready_stalled got=%b exp=0", s0_in_ready); end
        s0_stall = 1'b0;
        #1;
        checks++; if (s0_in_ready !== 1'b1) begin failures++; $display("FAIL s0_ready_comb got=%b exp=1", s0_in_ready); end
        s0_in_valid = 1'b0;
        step();
        checks++; if (s0_occupancy !== 2'd0) begin failures++; $display("FAIL s0_drain_occ got=%0d exp=0", s0_occupancy); end
    endtask

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    // Test sequence
    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_stall_masking();
        test_flush();
        test_skid0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
